// File: rtl/tword_splitter_pkg.sv
// Shared definitions for the wide-to-narrow stream splitter: sizing helper,
// controller state encoding and the narrow beat pair used by downstream consumers.
package tword_splitter_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_RATIO = 4;

  // Bits needed to index n beats; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] data;
    logic                 last;
  } beat_t;

endpackage

// File: rtl/tword_splitter_if.sv
// Wide upstream side (ACTL/NEXTL/DI/CNTL) and narrow downstream side
// (ACTH/NEXTH/DO/LASTH) of the splitter, bundled for port connection.
interface tword_splitter_if
  import tword_splitter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int RATIO = DEF_RATIO
);
  localparam int CW = cnt_width(RATIO);

  // Handshake: a transfer happens on a rising CLK edge where valid (ACTL/ACTH)
  // and ready (NEXTL/NEXTH) are both high; a raised valid with its payload
  // stays put until that edge, while ready may rise and fall freely.
  logic                   ACTL;
  logic                   NEXTL;
  logic [RATIO*WIDTH-1:0] DI;
  logic [CW-1:0]          CNTL;
  logic                   ACTH;
  logic                   NEXTH;
  logic [WIDTH-1:0]       DO;
  logic                   LASTH;

  modport master (
    output ACTL, DI, CNTL, NEXTH,
    input  NEXTL, ACTH, DO, LASTH
  );

  modport slave (
    input  ACTL, DI, CNTL, NEXTH,
    output NEXTL, ACTH, DO, LASTH
  );

endinterface

// File: rtl/tword_splitter.sv
// Serializes one wide word into 1..RATIO narrow beats, low slice first, with a
// registered output stage that can take the next word on the last-beat cycle.
module tword_splitter
  import tword_splitter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int RATIO = DEF_RATIO
) (
  input  logic             CLK,
  input  logic             RESET,
  tword_splitter_if.slave  bus,
  output state_t           state_dbg
);

  localparam int            CW      = cnt_width(RATIO);
  localparam logic [CW-1:0] CNT_MAX = CW'(RATIO - 1);

  state_t                       state_q, state_d;
  logic [RATIO-1:0][WIDTH-1:0]  hold_q;
  logic [CW-1:0]                cnt_q;
  logic [CW-1:0]                idx_q;
  logic                         acth_q;
  logic                         lasth_q;
  logic [WIDTH-1:0]             beat_q;

  logic          busy;
  logic          adv;
  logic          at_last;
  logic          emit;
  logic          fin;
  logic          nextl;
  logic          accept;
  logic [CW-1:0] cntl_clamped;

  // Out-of-range counts only exist when RATIO is not a power of two.
  generate
    if ((1 << CW) > RATIO) begin : g_clamp
      assign cntl_clamped = (bus.CNTL > CNT_MAX) ? CNT_MAX : bus.CNTL;
    end else begin : g_noclamp
      assign cntl_clamped = bus.CNTL;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    busy    = (state_q == ST_BUSY);
    adv     = ~acth_q | bus.NEXTH;
    at_last = (idx_q == cnt_q);
    emit    = busy & adv;
    fin     = emit & at_last;
    nextl   = ~busy | fin;
    accept  = bus.ACTL & nextl;
    if (accept) begin
      state_d = ST_BUSY;
    end else if (fin) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Holding register: a new word may overwrite it in the same cycle its
  // last beat moves into the output register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hold_q <= '0;
      cnt_q  <= '0;
      idx_q  <= '0;
    end else if (accept) begin
      hold_q <= bus.DI;
      cnt_q  <= cntl_clamped;
      idx_q  <= '0;
    end else if (emit && !at_last) begin
      idx_q  <= idx_q + CW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      acth_q  <= 1'b0;
      lasth_q <= 1'b0;
      beat_q  <= '0;
    end else if (emit) begin
      acth_q  <= 1'b1;
      lasth_q <= at_last;
      beat_q  <= hold_q[idx_q];
    end else if (adv) begin
      acth_q  <= 1'b0;
    end
  end

  assign bus.NEXTL = nextl;
  assign bus.ACTH  = acth_q;
  assign bus.LASTH = lasth_q;
  assign bus.DO    = beat_q;
  assign state_dbg = state_q;

endmodule
